// File: rtl/ddr_burst_arbiter_pkg.sv
// Shared types and defaults for the DDR burst arbiter slice.
// Holds FSM encoding, default bus widths and a width helper.
package ddr_burst_arbiter_pkg;

  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_LEN_W   = 10;
  localparam int DEF_TIMEOUT = 65535;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_burst_arbiter_rr_pick.sv
// Combinational round-robin picker for the DDR burst arbiter.
// Ports: req (request vector), last (previous winner) -> found, win.
module ddr_burst_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] win
);

  logic [W:0] idx;

  // Search starts one past the last winner and wraps.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = {1'b0, last} + (W+1)'(i);
      if (idx >= (W+1)'(N))
        idx = idx - (W+1)'(N);
      if (!found && req[idx[W-1:0]]) begin
        found = 1'b1;
        win   = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter sharing one DDR burst master among writers
// and readers; one burst in flight, grant held until finish/timeout.
// Ports:
//   axi_clk, rst_n (sync, active-low)
//   s_wr_* / s_rd_*  per-stream request side (flattened vectors)
//   m_wr_* / m_rd_*  single burst master side
//   busy, grant_id, err_timeout  status
module ddr_burst_arbiter
  import ddr_burst_arbiter_pkg::*;
#(
  parameter int N_WR           = 2,
  parameter int N_RD           = 2,
  parameter int AXI_ADDR_WIDTH = DEF_ADDR_W,
  parameter int AXI_DATA_WIDTH = DEF_DATA_W,
  parameter int LEN_WIDTH      = DEF_LEN_W,
  parameter int TIMEOUT_CYC    = DEF_TIMEOUT
) (
  input  logic                           axi_clk,
  input  logic                           rst_n,
  input  logic [N_WR-1:0]                s_wr_req,
  input  logic [N_WR*LEN_WIDTH-1:0]      s_wr_len,
  input  logic [N_WR*AXI_ADDR_WIDTH-1:0] s_wr_addr,
  input  logic [N_WR*AXI_DATA_WIDTH-1:0] s_wr_data,
  output logic [N_WR-1:0]                s_wr_data_req,
  output logic [N_WR-1:0]                s_wr_finish,
  input  logic [N_RD-1:0]                s_rd_req,
  input  logic [N_RD*LEN_WIDTH-1:0]      s_rd_len,
  input  logic [N_RD*AXI_ADDR_WIDTH-1:0] s_rd_addr,
  output logic [AXI_DATA_WIDTH-1:0]      s_rd_data,
  output logic [N_RD-1:0]                s_rd_valid,
  output logic [N_RD-1:0]                s_rd_finish,
  output logic                           m_wr_req,
  output logic [LEN_WIDTH-1:0]           m_wr_len,
  output logic [AXI_ADDR_WIDTH-1:0]      m_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]      m_wr_data,
  input  logic                           m_wr_data_req,
  input  logic                           m_wr_finish,
  output logic                           m_rd_req,
  output logic [LEN_WIDTH-1:0]           m_rd_len,
  output logic [AXI_ADDR_WIDTH-1:0]      m_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]      m_rd_data,
  input  logic                           m_rd_valid,
  input  logic                           m_rd_finish,
  output logic                           busy,
  output logic [clog2_min1(N_WR+N_RD)-1:0] grant_id,
  output logic                           err_timeout
);

  localparam int N  = N_WR + N_RD;
  localparam int GW = clog2_min1(N);
  localparam int WW = clog2_min1(N_WR);
  localparam int RW = clog2_min1(N_RD);
  localparam int TW = clog2_min1(TIMEOUT_CYC + 1);

  localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  arb_state_t state_q, state_d;

  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            hold_q, hold_d;
  logic            err_q, err_d;
  logic            mwr_q, mwr_d;
  logic            mrd_q, mrd_d;
  logic [N_WR-1:0] wfin_q, wfin_d;
  logic [N_RD-1:0] rfin_q, rfin_d;

  logic            pick_found;
  logic [GW-1:0]   pick_win;
  logic            grant_is_wr;
  logic [WW-1:0]   wr_sel;
  logic [RW-1:0]   rd_sel;
  logic [N_WR-1:0] wr_oh;
  logic [N_RD-1:0] rd_oh;
  logic            fin_hit;
  logic            tmo_hit;

  ddr_burst_arbiter_rr_pick #(
    .N (N),
    .W (GW)
  ) u_rr_pick (
    .req   ({s_rd_req, s_wr_req}),
    .last  (last_q),
    .found (pick_found),
    .win   (pick_win)
  );

  assign grant_is_wr = (grant_q < GW'(N_WR));
  assign wr_sel = grant_is_wr ? WW'(grant_q) : '0;
  assign rd_sel = RW'(grant_q - GW'(N_WR));

  for (genvar i = 0; i < N_WR; i++) begin : g_wr_oh
    assign wr_oh[i] = grant_is_wr && (wr_sel == WW'(i));
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_rd_oh
    assign rd_oh[i] = !grant_is_wr && (rd_sel == RW'(i));
  end

  // Only the granted channel's finish counts.
  assign fin_hit = grant_is_wr ? m_wr_finish : m_rd_finish;
  assign tmo_hit = TMO_EN && (timer_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    err_d   = err_q;
    mwr_d   = mwr_q;
    mrd_d   = mrd_q;
    wfin_d  = '0;
    rfin_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_BUSY;
          grant_d = pick_win;
          last_d  = pick_win;
          timer_d = '0;
          if (pick_win < GW'(N_WR))
            mwr_d = 1'b1;
          else
            mrd_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (fin_hit || tmo_hit) begin
          state_d = ST_HOLD;
          hold_d  = 1'b0;
          mwr_d   = 1'b0;
          mrd_d   = 1'b0;
          wfin_d  = wr_oh;
          rfin_d  = rd_oh;
          // A real finish wins a tie with the watchdog.
          if (!fin_hit)
            err_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_HOLD: begin
        // Two idle cycles let the requester drop its level req.
        if (hold_q) begin
          state_d = ST_IDLE;
          hold_d  = 1'b0;
        end else begin
          hold_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N - 1);
      timer_q <= '0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      mwr_q   <= 1'b0;
      mrd_q   <= 1'b0;
      wfin_q  <= '0;
      rfin_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      mwr_q   <= mwr_d;
      mrd_q   <= mrd_d;
      wfin_q  <= wfin_d;
      rfin_q  <= rfin_d;
    end
  end

  // Burst fields are zeroed whenever that master port is idle.
  assign m_wr_req  = mwr_q;
  assign m_wr_len  = mwr_q ?
    s_wr_len[int'(wr_sel)*LEN_WIDTH +: LEN_WIDTH] : '0;
  assign m_wr_addr = mwr_q ?
    s_wr_addr[int'(wr_sel)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] : '0;
  assign m_wr_data = mwr_q ?
    s_wr_data[int'(wr_sel)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : '0;

  assign m_rd_req  = mrd_q;
  assign m_rd_len  = mrd_q ?
    s_rd_len[int'(rd_sel)*LEN_WIDTH +: LEN_WIDTH] : '0;
  assign m_rd_addr = mrd_q ?
    s_rd_addr[int'(rd_sel)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] : '0;

  assign s_wr_data_req = wr_oh & {N_WR{mwr_q & m_wr_data_req}};
  assign s_rd_valid    = rd_oh & {N_RD{mrd_q & m_rd_valid}};
  assign s_rd_data     = mrd_q ? m_rd_data : '0;

  assign s_wr_finish = wfin_q;
  assign s_rd_finish = rfin_q;
  assign busy        = (state_q == ST_BUSY);
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Scoreboard bench for ddr_burst_arbiter (2 writers, 2 readers).
// Directed stimulus; monitor pops expected grants/finishes.
module tb_ddr_burst_arbiter;

  localparam int NW  = 2;
  localparam int NR  = 2;
  localparam int AW  = 28;
  localparam int DW  = 32;
  localparam int LW  = 10;
  localparam int TMO = 100;

  logic              axi_clk = 1'b0;
  logic              rst_n;
  logic [NW-1:0]     s_wr_req;
  logic [NW*LW-1:0]  s_wr_len;
  logic [NW*AW-1:0]  s_wr_addr;
  logic [NW*DW-1:0]  s_wr_data;
  logic [NW-1:0]     s_wr_data_req;
  logic [NW-1:0]     s_wr_finish;
  logic [NR-1:0]     s_rd_req;
  logic [NR*LW-1:0]  s_rd_len;
  logic [NR*AW-1:0]  s_rd_addr;
  logic [DW-1:0]     s_rd_data;
  logic [NR-1:0]     s_rd_valid;
  logic [NR-1:0]     s_rd_finish;
  logic              m_wr_req;
  logic [LW-1:0]     m_wr_len;
  logic [AW-1:0]     m_wr_addr;
  logic [DW-1:0]     m_wr_data;
  logic              m_wr_data_req;
  logic              m_wr_finish;
  logic              m_rd_req;
  logic [LW-1:0]     m_rd_len;
  logic [AW-1:0]     m_rd_addr;
  logic [DW-1:0]     m_rd_data;
  logic              m_rd_valid;
  logic              m_rd_finish;
  logic              busy;
  logic [1:0]        grant_id;
  logic              err_timeout;

  ddr_burst_arbiter #(
    .N_WR (NW), .N_RD (NR),
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .LEN_WIDTH (LW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .axi_clk (axi_clk), .rst_n (rst_n),
    .s_wr_req (s_wr_req), .s_wr_len (s_wr_len),
    .s_wr_addr (s_wr_addr), .s_wr_data (s_wr_data),
    .s_wr_data_req (s_wr_data_req),
    .s_wr_finish (s_wr_finish),
    .s_rd_req (s_rd_req), .s_rd_len (s_rd_len),
    .s_rd_addr (s_rd_addr), .s_rd_data (s_rd_data),
    .s_rd_valid (s_rd_valid),
    .s_rd_finish (s_rd_finish),
    .m_wr_req (m_wr_req), .m_wr_len (m_wr_len),
    .m_wr_addr (m_wr_addr), .m_wr_data (m_wr_data),
    .m_wr_data_req (m_wr_data_req),
    .m_wr_finish (m_wr_finish),
    .m_rd_req (m_rd_req), .m_rd_len (m_rd_len),
    .m_rd_addr (m_rd_addr), .m_rd_data (m_rd_data),
    .m_rd_valid (m_rd_valid),
    .m_rd_finish (m_rd_finish),
    .busy (busy), .grant_id (grant_id),
    .err_timeout (err_timeout)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    int         port;
    logic [27:0] addr;
    logic [9:0]  len;
  } grant_t;

  typedef struct {
    int port;
    bit err;
    int beats;
  } fin_t;

  grant_t gq[$];
  fin_t   fq[$];

  logic [27:0] addr_t [4];
  logic [9:0]  len_t  [4];
  logic [31:0] wdat_t [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic push_grant(input int p);
    grant_t g;
    g.port = p;
    g.addr = addr_t[p];
    g.len  = len_t[p];
    gq.push_back(g);
  endtask

  task automatic push_fin(input int p, input bit e, input int b);
    fin_t f;
    f.port  = p;
    f.err   = e;
    f.beats = b;
    fq.push_back(f);
  endtask

  task automatic wait_grant(output bit ok);
    int w;
    w = 0;
    while (!(m_wr_req || m_rd_req) && w < 50) begin
      tick();
      w++;
    end
    ok = m_wr_req || m_rd_req;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL grant_wait: no m_req after %0d cycles", w);
    end
  endtask

  task automatic serve(input int beats);
    bit ok;
    bit wr;
    wait_grant(ok);
    if (!ok) return;
    wr = m_wr_req;
    for (int b = 0; b < beats; b++) begin
      if (wr) m_wr_data_req = 1'b1;
      else begin
        m_rd_valid = 1'b1;
        m_rd_data  = 32'hA500_0000 + 32'(b);
      end
      tick();
    end
    m_wr_data_req = 1'b0;
    m_rd_valid    = 1'b0;
    if (wr) m_wr_finish = 1'b1;
    else    m_rd_finish = 1'b1;
    tick();
    m_wr_finish = 1'b0;
    m_rd_finish = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_m_wr_req"}, m_wr_req, 0);
    chk({tag, "_m_rd_req"}, m_rd_req, 0);
    chk({tag, "_m_wr_addr"}, m_wr_addr, 0);
    chk({tag, "_wr_fin"}, s_wr_finish, 0);
    chk({tag, "_rd_fin"}, s_rd_finish, 0);
    chk({tag, "_wr_dreq"}, s_wr_data_req, 0);
  endtask

  // Monitor
  initial begin
    grant_t     g;
    fin_t       f;
    int         cur;
    bit         in_b;
    int         beats;
    logic       pw, pr;
    logic [1:0] ew, er;
    cur = 0; in_b = 0; beats = 0; pw = 0; pr = 0;
    forever begin
      @(negedge axi_clk);
      if (rst_n !== 1'b1) begin
        in_b = 0; pw = 0; pr = 0;
      end else begin
        if ((m_wr_req && !pw) || (m_rd_req && !pr)) begin
          if (gq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_grant: got port %0d expected none",
                     grant_id);
          end else begin
            g = gq.pop_front();
            chk("grant_id", grant_id, g.port);
            chk("grant_type", m_wr_req, g.port < NW);
            chk("grant_addr", (g.port < NW) ? m_wr_addr : m_rd_addr,
                g.addr);
            chk("grant_len", (g.port < NW) ? m_wr_len : m_rd_len,
                g.len);
            if (g.port < NW)
              chk("grant_wdata", m_wr_data, wdat_t[g.port]);
            cur = g.port; in_b = 1; beats = 0;
          end
        end
        if (m_wr_data_req) begin
          ew = (in_b && cur < NW) ? 2'(1 << cur) : 2'b00;
          chk("wr_dreq_route", s_wr_data_req, ew);
          if (s_wr_data_req != 0) beats++;
        end
        if (m_rd_valid) begin
          er = (in_b && cur >= NW) ? 2'(1 << (cur - NW)) : 2'b00;
          chk("rd_valid_route", s_rd_valid, er);
          if (in_b && cur >= NW)
            chk("rd_data", s_rd_data, m_rd_data);
          if (s_rd_valid != 0) beats++;
        end
        if (s_wr_finish != 0 || s_rd_finish != 0) begin
          if (fq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_finish: got %b expected none",
                     {s_rd_finish, s_wr_finish});
          end else begin
            f = fq.pop_front();
            chk("finish_port", {s_rd_finish, s_wr_finish},
                64'(1) << f.port);
            chk("finish_err", err_timeout, f.err);
            chk("finish_beats", beats, f.beats);
            chk("finish_busy", busy, 0);
          end
          in_b = 0;
        end
        pw = m_wr_req;
        pr = m_rd_req;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  // Stimulus
  initial begin
    bit ok;
    int n;
    int w;
    addr_t[0] = 28'h0000100; len_t[0] = 10'd16;
    addr_t[1] = 28'h0002000; len_t[1] = 10'd8;
    addr_t[2] = 28'h0003400; len_t[2] = 10'd4;
    addr_t[3] = 28'h0004C00; len_t[3] = 10'd32;
    wdat_t[0] = 32'hDEAD_0000;
    wdat_t[1] = 32'hBEEF_1111;
    rst_n = 1'b0;
    s_wr_req = '0; s_rd_req = '0;
    s_wr_len  = {len_t[1], len_t[0]};
    s_rd_len  = {len_t[3], len_t[2]};
    s_wr_addr = {addr_t[1], addr_t[0]};
    s_rd_addr = {addr_t[3], addr_t[2]};
    s_wr_data = {wdat_t[1], wdat_t[0]};
    m_wr_data_req = 0; m_wr_finish = 0;
    m_rd_valid = 0; m_rd_finish = 0; m_rd_data = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // single writer burst, then no re-grant after drop
    push_grant(0);
    push_fin(0, 0, 16);
    s_wr_req[0] = 1'b1;
    tick();
    chk("t1_latency", m_wr_req, 1);
    serve(16);
    tick();
    s_wr_req[0] = 1'b0;
    repeat (6) tick();
    chk("t4_idle_busy", busy, 0);
    chk("t4_no_regrant", m_wr_req, 0);

    // reset mid-burst
    push_grant(1);
    s_wr_req[1] = 1'b1;
    wait_grant(ok);
    for (int b = 0; b < 5; b++) begin
      m_wr_data_req = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk_zero("t5");
    s_wr_req = '0;
    m_wr_data_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // all four requesting: 0,1,2,3,0
    push_grant(0); push_fin(0, 0, 2);
    push_grant(1); push_fin(1, 0, 2);
    push_grant(2); push_fin(2, 0, 2);
    push_grant(3); push_fin(3, 0, 2);
    push_grant(0); push_fin(0, 0, 2);
    s_wr_req = 2'b11;
    s_rd_req = 2'b11;
    for (int k = 0; k < 5; k++) serve(2);
    s_wr_req = '0;
    s_rd_req = '0;
    repeat (6) tick();
    chk("t2_idle_busy", busy, 0);

    // reader 3 stalls: watchdog fires
    push_grant(3);
    push_fin(3, 1, 0);
    s_rd_req[1] = 1'b1;
    wait_grant(ok);
    n = 0;
    w = 0;
    while (s_rd_finish[1] !== 1'b1 && w < 300) begin
      if (busy) n++;
      tick();
      w++;
    end
    chk("t3_busy_cycles", n, 100);
    chk("t3_err_set", err_timeout, 1);
    tick();
    s_rd_req[1] = 1'b0;
    repeat (4) tick();
    chk("t3_err_sticky", err_timeout, 1);
    push_grant(0);
    push_fin(0, 1, 3);
    s_wr_req[0] = 1'b1;
    serve(3);
    tick();
    s_wr_req[0] = 1'b0;
    repeat (4) tick();
    chk("t3_err_after", err_timeout, 1);

    // finish on the timeout cycle
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t6_err_clear", err_timeout, 0);
    push_grant(0);
    push_fin(0, 0, 0);
    s_wr_req[0] = 1'b1;
    wait_grant(ok);
    repeat (99) tick();
    chk("t6_still_busy", busy, 1);
    m_wr_finish = 1'b1;
    tick();
    m_wr_finish = 1'b0;
    tick();
    s_wr_req[0] = 1'b0;
    repeat (4) tick();
    chk("t6_err", err_timeout, 0);
    chk("t6_idle", busy, 0);

    chk("grant_q_empty", gq.size(), 0);
    chk("fin_q_empty", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
